// File: rtl/rbt_s_pre_parser_fifo.sv
// RBT-S header pre-parser: builds packet metadata at acceptance and buffers
// header beats in a small FIFO so input ready depends only on stored occupancy.
module rbt_s_pre_parser_fifo #(
  parameter int META_WIDTH         = 32,
  parameter int HEADER_WIDTH       = 2048,
  parameter int USER_WIDTH         = 36,
  parameter int PKT_METADATA_WIDTH = 272,
  parameter int DEPTH              = 4,
  parameter int TS_WIDTH           = 32,
  parameter int MIN_HDR_LEN        = 14,
  parameter int DROP_EN            = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_proto_hdr_valid,
  output logic                          in_proto_hdr_ready,
  input  logic [15:0]                   in_proto_hdr_length,
  input  logic [15:0]                   in_proto_hdr_pktlen,
  input  logic [HEADER_WIDTH-1:0]       in_proto_hdr_data,
  input  logic [USER_WIDTH-1:0]         in_proto_hdr_tuser,
  input  logic [META_WIDTH-1:0]         in_proto_hdr_meta,
  output logic                          out_proto_hdr_valid,
  input  logic                          out_proto_hdr_ready,
  output logic [HEADER_WIDTH-1:0]       out_proto_hdr_data,
  output logic [PKT_METADATA_WIDTH-1:0] out_proto_hdr_pkt_metadata,
  output logic [15:0]                   out_proto_hdr_length,
  output logic [$clog2(DEPTH):0]        fifo_level,
  output logic [31:0]                   drop_count
);

  localparam int PTR_W     = $clog2(DEPTH);
  localparam int LVL_W     = PTR_W + 1;
  localparam int HDR_BYTES = HEADER_WIDTH / 8;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [PTR_W-1:0]    rd_ptr_reg;
  logic [LVL_W-1:0]    level_reg;
  logic [LVL_W-1:0]    level_next;
  logic [31:0]         drop_count_reg;
  logic [TS_WIDTH-1:0] ts_reg;

  logic [HEADER_WIDTH-1:0]       data_mem [DEPTH];
  logic [PKT_METADATA_WIDTH-1:0] meta_mem [DEPTH];
  logic [15:0]                   len_mem  [DEPTH];

  logic [PKT_METADATA_WIDTH-1:0] meta_next;
  logic accept;
  logic malformed;
  logic drop_hit;
  logic push_en;
  logic pop_en;
  logic unused_tuser;

  assign unused_tuser = ^in_proto_hdr_tuser[USER_WIDTH-1:35];

  assign in_proto_hdr_ready  = (level_reg != FULL_LVL);
  assign out_proto_hdr_valid = (level_reg != '0);

  assign accept    = in_proto_hdr_valid & in_proto_hdr_ready;
  assign malformed = (in_proto_hdr_length < 16'(MIN_HDR_LEN))
                   || (in_proto_hdr_length > 16'(HDR_BYTES))
                   || (in_proto_hdr_pktlen < in_proto_hdr_length);
  assign drop_hit  = accept && (DROP_EN != 0) && malformed;
  assign push_en   = accept && !drop_hit;
  assign pop_en    = out_proto_hdr_valid & out_proto_hdr_ready;

  // Metadata is frozen at acceptance, including the timestamp of that cycle.
  always_comb begin
    meta_next                              = '0;
    meta_next[7:0]                         = in_proto_hdr_tuser[7:0];
    meta_next[15:8]                        = in_proto_hdr_tuser[15:8];
    meta_next[23:16]                       = in_proto_hdr_tuser[23:16];
    meta_next[39:24]                       = in_proto_hdr_pktlen;
    meta_next[40 +: TS_WIDTH]              = ts_reg;
    meta_next[40+TS_WIDTH +: META_WIDTH]   = in_proto_hdr_meta;
    meta_next[245:241]                     = in_proto_hdr_tuser[34:30];
    meta_next[251:246]                     = in_proto_hdr_tuser[29:24];
  end

  always_comb begin
    level_next = level_reg;
    case ({push_en, pop_en})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      drop_count_reg <= '0;
      ts_reg         <= '0;
    end else begin
      ts_reg    <= ts_reg + TS_WIDTH'(1);
      level_reg <= level_next;
      if (push_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (drop_hit && (drop_count_reg != 32'hFFFF_FFFF))
        drop_count_reg <= drop_count_reg + 32'd1;
    end
  end

  // Storage carries no reset; stale entries are masked by the valid gate below.
  always_ff @(posedge clk) begin
    if (push_en) begin
      data_mem[wr_ptr_reg] <= in_proto_hdr_data;
      meta_mem[wr_ptr_reg] <= meta_next;
      len_mem[wr_ptr_reg]  <= in_proto_hdr_length;
    end
  end

  assign out_proto_hdr_data         = out_proto_hdr_valid ? data_mem[rd_ptr_reg] : '0;
  assign out_proto_hdr_pkt_metadata = out_proto_hdr_valid ? meta_mem[rd_ptr_reg] : '0;
  assign out_proto_hdr_length       = out_proto_hdr_valid ? len_mem[rd_ptr_reg]  : '0;
  assign fifo_level                 = level_reg;
  assign drop_count                 = drop_count_reg;

endmodule

// File: tb/tb_rbt_s_pre_parser_fifo.sv
// Self-checking bench: queue-based reference model, boundary vector table and
// hand-written sequences for fill, drop, saturation and reset flush.
module tb_rbt_s_pre_parser_fifo;
  localparam int META_WIDTH         = 32;
  localparam int HEADER_WIDTH       = 2048;
  localparam int USER_WIDTH         = 36;
  localparam int PKT_METADATA_WIDTH = 272;
  localparam int DEPTH              = 4;
  localparam int TS_WIDTH           = 32;
  localparam int MIN_HDR_LEN        = 14;
  localparam int DROP_EN            = 1;
  localparam int LVL_W              = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          rst;
  logic                          in_valid;
  logic                          in_ready;
  logic [15:0]                   in_len;
  logic [15:0]                   in_pktlen;
  logic [HEADER_WIDTH-1:0]       in_data;
  logic [USER_WIDTH-1:0]         in_tuser;
  logic [META_WIDTH-1:0]         in_meta;
  logic                          out_valid;
  logic                          out_ready;
  logic [HEADER_WIDTH-1:0]       out_data;
  logic [PKT_METADATA_WIDTH-1:0] out_md;
  logic [15:0]                   out_len;
  logic [LVL_W-1:0]              level;
  logic [31:0]                   drops;

  rbt_s_pre_parser_fifo #(
    .META_WIDTH(META_WIDTH), .HEADER_WIDTH(HEADER_WIDTH), .USER_WIDTH(USER_WIDTH),
    .PKT_METADATA_WIDTH(PKT_METADATA_WIDTH), .DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH),
    .MIN_HDR_LEN(MIN_HDR_LEN), .DROP_EN(DROP_EN)
  ) dut (
    .clk(clk), .rst(rst),
    .in_proto_hdr_valid(in_valid), .in_proto_hdr_ready(in_ready),
    .in_proto_hdr_length(in_len), .in_proto_hdr_pktlen(in_pktlen),
    .in_proto_hdr_data(in_data), .in_proto_hdr_tuser(in_tuser),
    .in_proto_hdr_meta(in_meta),
    .out_proto_hdr_valid(out_valid), .out_proto_hdr_ready(out_ready),
    .out_proto_hdr_data(out_data), .out_proto_hdr_pkt_metadata(out_md),
    .out_proto_hdr_length(out_len),
    .fifo_level(level), .drop_count(drops)
  );

  typedef struct {
    logic [HEADER_WIDTH-1:0]       data;
    logic [PKT_METADATA_WIDTH-1:0] md;
    logic [15:0]                   len;
  } ent_t;

  typedef struct {
    logic [15:0] len;
    logic [15:0] pktlen;
    bit          exp_drop;
  } vec_t;

  ent_t          q[$];
  logic [31:0]   m_drops;
  logic [TS_WIDTH-1:0] m_ts;
  bit            chk_en;
  int            tests;
  int            fails;

  task automatic chk(input string name, input logic [PKT_METADATA_WIDTH-1:0] got,
                     input logic [PKT_METADATA_WIDTH-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [HEADER_WIDTH-1:0] got,
                          input logic [HEADER_WIDTH-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got_lo=%h exp_lo=%h", name, got[63:0], exp[63:0]);
    end
  endtask

  function automatic bit is_malformed(input logic [15:0] l, input logic [15:0] p);
    return (int'(l) < MIN_HDR_LEN) || (int'(l) > HEADER_WIDTH / 8) || (p < l);
  endfunction

  function automatic logic [PKT_METADATA_WIDTH-1:0] build_md(
      input logic [USER_WIDTH-1:0] tu, input logic [15:0] pl,
      input logic [META_WIDTH-1:0] mt, input logic [TS_WIDTH-1:0] ts);
    logic [PKT_METADATA_WIDTH-1:0] md;
    md = PKT_METADATA_WIDTH'(tu[23:0]);
    md = md | (PKT_METADATA_WIDTH'(pl) << 24);
    md = md | (PKT_METADATA_WIDTH'(ts) << 40);
    md = md | (PKT_METADATA_WIDTH'(mt) << (40 + TS_WIDTH));
    md = md | (PKT_METADATA_WIDTH'(tu[34:30]) << 241);
    md = md | (PKT_METADATA_WIDTH'(tu[29:24]) << 246);
    return md;
  endfunction

  task automatic check_outputs();
    if (chk_en) begin
      chk("in_ready", in_ready, (q.size() != DEPTH));
      chk("out_valid", out_valid, (q.size() != 0));
      chk("fifo_level", level, q.size());
      chk("drop_count", drops, m_drops);
      if (q.size() != 0) begin
        chk_data("out_data", out_data, q[0].data);
        chk("out_md", out_md, q[0].md);
        chk("out_len", out_len, q[0].len);
      end else begin
        chk_data("out_data_idle", out_data, '0);
        chk("out_md_idle", out_md, '0);
        chk("out_len_idle", out_len, '0);
      end
    end
  endtask

  // One clock of stimulus: check current outputs, then advance DUT and model.
  task automatic cycle(output bit acc);
    bit   pop;
    bit   mal;
    ent_t e;
    check_outputs();
    acc    = rst && in_valid && (q.size() != DEPTH);
    pop    = rst && out_ready && (q.size() != 0);
    mal    = is_malformed(in_len, in_pktlen);
    e.data = in_data;
    e.md   = build_md(in_tuser, in_pktlen, in_meta, m_ts);
    e.len  = in_len;
    @(posedge clk);
    if (!rst) begin
      q.delete();
      m_drops = '0;
      m_ts    = '0;
    end else begin
      if (pop) begin
        $display("[TB] pop  len=%0d md_lo=%h", q[0].len, q[0].md[39:0]);
        void'(q.pop_front());
      end
      if (acc) begin
        if (DROP_EN != 0 && mal) begin
          if (m_drops != 32'hFFFF_FFFF) m_drops++;
          $display("[TB] drop len=%0d pktlen=%0d", e.len, in_pktlen);
        end else begin
          q.push_back(e);
          $display("[TB] push len=%0d md_lo=%h", e.len, e.md[39:0]);
        end
      end
      m_ts++;
    end
    #1;
  endtask

  task automatic rand_beat(input bit bad);
    for (int i = 0; i < HEADER_WIDTH / 32; i++) in_data[i*32 +: 32] = $urandom;
    in_tuser = {4'($urandom), 32'($urandom)};
    in_meta  = $urandom;
    if (bad) begin
      in_len    = 16'($urandom_range(0, MIN_HDR_LEN - 1));
      in_pktlen = 16'($urandom);
    end else begin
      in_len    = 16'($urandom_range(MIN_HDR_LEN, HEADER_WIDTH / 8));
      in_pktlen = 16'($urandom_range(int'(in_len), 65535));
    end
  endtask

  task automatic do_reset();
    bit a;
    rst = 1'b0;
    cycle(a);
    rst = 1'b1;
  endtask

  initial begin
    bit   a;
    int   n_acc;
    vec_t vecs[8];
    logic [HEADER_WIDTH-1:0] beat0;
    logic [HEADER_WIDTH-1:0] fresh;
    logic [31:0] dc_before;

    tests = 0; fails = 0; chk_en = 1'b0;
    m_drops = '0; m_ts = '0;
    in_valid = 0; out_ready = 0; in_len = 0; in_pktlen = 0;
    in_data = '0; in_tuser = '0; in_meta = '0; rst = 1'b0;
    cycle(a);
    cycle(a);
    chk_en = 1'b1;
    rst = 1'b1;

    // Single beat accepted at timestamp 10
    for (int i = 0; i < 10; i++) cycle(a);
    in_valid = 1; in_tuser = 36'h0_5A_07_03_01; in_len = 16'd64;
    in_pktlen = 16'd1500; in_meta = 32'hDEAD_BEEF;
    for (int i = 0; i < HEADER_WIDTH / 32; i++) in_data[i*32 +: 32] = 32'h1000 + i;
    cycle(a);
    in_valid = 0;
    chk("single_valid", out_valid, 1'b1);
    chk("single_md", out_md, (272'h1A << 246) | (272'h1 << 241)
                             | 272'hDEADBEEF_0000000A_05DC_07_03_01);
    chk("single_len", out_len, 16'd64);
    out_ready = 1;
    cycle(a);
    out_ready = 0;

    // Fill with out_ready low: only DEPTH beats accepted
    n_acc = 0;
    beat0 = '0;
    in_valid = 1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      rand_beat(1'b0);
      if (i == 0) beat0 = in_data;
      cycle(a);
      if (a) n_acc++;
    end
    chk("fill_accepted", n_acc, DEPTH);
    chk("fill_level", level, DEPTH);
    chk("fill_ready", in_ready, 1'b0);
    chk_data("fill_head", out_data, beat0);

    // Continuous push and pop from full
    out_ready = 1;
    for (int i = 0; i < 12; i++) begin
      rand_beat(1'b0);
      cycle(a);
      chk("stream_level_bound", (int'(level) <= DEPTH), 1'b1);
    end
    in_valid = 0;
    for (int i = 0; i < DEPTH + 2; i++) cycle(a);
    out_ready = 0;

    // Malformed beats after reset
    do_reset();
    out_ready = 1; in_valid = 1;
    rand_beat(1'b0); in_len = 16'd8;   in_pktlen = 16'd1500; cycle(a);
    rand_beat(1'b0); in_len = 16'd300; in_pktlen = 16'd1500; cycle(a);
    rand_beat(1'b0); in_len = 16'd100; in_pktlen = 16'd50;   cycle(a);
    in_valid = 0;
    chk("mal_drop_count", drops, 32'd3);
    chk("mal_level", level, 0);
    chk("mal_valid", out_valid, 1'b0);
    out_ready = 0;

    // Boundary classification table
    vecs[0] = '{16'd13,  16'd100,   1'b1};
    vecs[1] = '{16'd14,  16'd14,    1'b0};
    vecs[2] = '{16'd256, 16'd256,   1'b0};
    vecs[3] = '{16'd257, 16'd300,   1'b1};
    vecs[4] = '{16'd64,  16'd63,    1'b1};
    vecs[5] = '{16'd64,  16'd64,    1'b0};
    vecs[6] = '{16'd0,   16'd0,     1'b1};
    vecs[7] = '{16'd200, 16'd65535, 1'b0};
    for (int v = 0; v < 8; v++) begin
      dc_before = drops;
      rand_beat(1'b0);
      in_len = vecs[v].len; in_pktlen = vecs[v].pktlen;
      in_valid = 1;
      cycle(a);
      in_valid = 0;
      chk("vec_out_valid", out_valid, !vecs[v].exp_drop);
      chk("vec_drop_delta", drops - dc_before, 32'(vecs[v].exp_drop));
      out_ready = 1;
      cycle(a);
      out_ready = 0;
    end

    // Saturation of drop_count via a preload force
    @(negedge clk);
    force dut.drop_count_reg = 32'hFFFF_FFFE;
    @(posedge clk);
    m_ts++;
    #1;
    release dut.drop_count_reg;
    m_drops = 32'hFFFF_FFFE;
    rand_beat(1'b1);
    in_valid = 1;
    cycle(a);
    chk("sat_step", drops, 32'hFFFF_FFFF);
    cycle(a);
    in_valid = 0;
    cycle(a);
    chk("sat_hold", drops, 32'hFFFF_FFFF);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rand_beat($urandom_range(0, 7) == 0);
      cycle(a);
    end
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < DEPTH + 2; i++) cycle(a);

    // Reset flushes buffered entries mid-stream
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      rand_beat(1'b0);
      cycle(a);
    end
    rand_beat(1'b1);
    cycle(a);
    in_valid = 0;
    chk("pre_flush_level", level, 3);
    do_reset();
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_level", level, 0);
    chk("flush_drops", drops, 32'd0);
    rand_beat(1'b0);
    fresh = in_data;
    in_valid = 1;
    cycle(a);
    in_valid = 0;
    chk_data("flush_new_head", out_data, fresh);
    out_ready = 1;
    cycle(a);
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
